eth_mac_tx_framer: RTL

- Transmit-side counterpart of the UDP-stack receive CRC checker/buffer.
- Accepts a frame byte stream (destination MAC through payload) from the upper TX layer using a valid/ready handshake.
- Emits a GMII-style byte stream in this order: preamble, SFD, frame bytes, zero padding to minimum length, CRC-32 FCS, then an enforced inter-frame gap.
- Sits between the UDP/ARP TX mux and the GMII TX interface.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/crc32_d8.sv | 26 ++
 rtl/eth_mac_tx_framer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framer state encoding and CRC helpers.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // Width of the shared byte / preamble / FCS / gap counter.
  localparam int unsigned CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAD,
    FCS,
    UNDERRUN,
    GAP
  } tx_state_e;

  // The CRC is computed LSB-first, so the update uses the mirrored polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-parallel CRC-32 (reflected) next-state; shared with the RX checker.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [7:0]  i_data,
  input  logic [31:0] i_crc,
  output logic [31:0] o_crc
);

  localparam logic [31:0] PolyRefl = bit_reverse32(CRC32_POLY);

  // Eight unrolled LSB-first shift steps, one per data bit.
  always_comb begin
    logic [31:0] c;
    c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ i_data[i]) begin
        c = (c >> 1) ^ PolyRefl;
      end else begin
        c = c >> 1;
      end
    end
    o_crc = c;
  end

endmodule

// File: rtl/eth_mac_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-frame gap onto GMII.
module eth_mac_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned P_FRAME_GAP    = 12,
  parameter int unsigned P_MIN_LEN      = 60,
  parameter int unsigned P_PREAMBLE_LEN = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_pre_data,
  input  logic       i_pre_valid,
  input  logic       i_pre_last,
  output logic       o_pre_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic       o_underrun,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] MinLen  = CNT_W'(P_MIN_LEN);
  localparam logic [CNT_W-1:0] PreLen  = CNT_W'(P_PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(P_FRAME_GAP - 1);

  tx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [7:0]       crc_in;
  logic [7:0]       fcs_byte;

  // Pad bytes feed zeros into the CRC; otherwise the upstream byte.
  assign crc_in  = (state == PAD) ? 8'h00 : i_pre_data;
  // Saturating byte count; saturation never ends a frame early.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  assign o_pre_ready = (state == DATA) || (state == UNDERRUN);
  assign o_busy      = (state != IDLE);

  crc32_d8 u_crc32_d8 (
    .i_data (crc_in),
    .i_crc  (crc),
    .o_crc  (crc_next)
  );

  // Select the FCS byte, least significant byte first.
  always_comb begin
    fcs_byte = 8'h00;
    unique case (cnt[1:0])
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  // Framing FSM with registered GMII outputs; cnt is reused per state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      crc        <= CRC32_INIT;
      o_tx_data  <= 8'h00;
      o_tx_en    <= 1'b0;
      o_tx_er    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_tx_er    <= 1'b0;
      o_underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          cnt       <= '0;
          crc       <= CRC32_INIT;
          if (i_pre_valid) state <= PRE;
        end
        PRE: begin
          o_tx_en <= 1'b1;
          crc     <= CRC32_INIT;
          if (cnt < PreLen) begin
            o_tx_data <= ETH_PREAMBLE;
            cnt       <= cnt + 1'b1;
          end else begin
            o_tx_data <= ETH_SFD;
            cnt       <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          o_tx_en <= 1'b1;
          if (i_pre_valid) begin
            o_tx_data <= i_pre_data;
            crc       <= crc_next;
            cnt       <= cnt_inc;
            if (i_pre_last) begin
              if (cnt_inc < MinLen) begin
                state <= PAD;
              end else begin
                cnt   <= '0;
                state <= FCS;
              end
            end
          end else begin
            // Upstream starved mid-frame: poison the frame on the wire.
            o_tx_data  <= 8'h00;
            o_tx_er    <= 1'b1;
            o_underrun <= 1'b1;
            state      <= UNDERRUN;
          end
        end
        PAD: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= 8'h00;
          crc       <= crc_next;
          if (cnt_inc >= MinLen) begin
            cnt   <= '0;
            state <= FCS;
          end else begin
            cnt <= cnt_inc;
          end
        end
        FCS: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= fcs_byte;
          if (cnt[1:0] == 2'd3) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UNDERRUN: begin
          // Drain the rest of the aborted frame without transmitting it.
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (i_pre_valid && i_pre_last) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (cnt == GapLast) begin
            cnt   <= '0;
            crc   <= CRC32_INIT;
            state <= i_pre_valid ? PRE : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
